// File: rtl/ifetch_prefetch_buf_pkg.sv
// ifetch_prefetch_buf_pkg: shared constants and PC helper for the instruction prefetch buffer.
package ifetch_prefetch_buf_pkg;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction
endpackage

// File: rtl/ifetch_prefetch_buf_pfb_fifo.sv
// pfb_fifo: DEPTH x 32 synchronous FIFO holding prefetched instruction words.
module pfb_fifo
    import ifetch_prefetch_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [31:0]              i_wdata,
    input  logic                     i_pop,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [31:0]              o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   mem_q [DEPTH];

    // flush wins over a same-cycle push
    always_comb begin
        rd_d    = i_flush ? '0 : rd_q + AW'(i_pop);
        wr_d    = i_flush ? '0 : wr_q + AW'(i_push);
        cnt_d   = i_flush ? '0 : cnt_q + (AW+1)'(i_push) - (AW+1)'(i_pop);
        o_count = cnt_q;
        o_head  = (cnt_q != '0) ? mem_q[rd_q] : INST_NOP;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push & ~i_flush) mem_q[wr_q] <= i_wdata;
    end
endmodule

// File: rtl/ifetch_prefetch_buf.sv
// ifetch_prefetch_buf: sequential instruction prefetcher between the IF stage and instruction memory.
// Keeps up to DEPTH words buffered or in flight; a non-sequential IF address flushes and restarts.
module ifetch_prefetch_buf
    import ifetch_prefetch_buf_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_ack,
    output logic        o_if_rsp,
    output logic [31:0] o_if_data,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0] exp_pc_q, exp_pc_d, fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, count;
    logic [CW:0]   used;
    logic [31:0]   head;
    logic          redirect, pop, push, drop, gnt;

    pfb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (redirect),
        .i_push  (push),
        .i_wdata (i_mem_rdata),
        .i_pop   (pop),
        .o_count (count),
        .o_head  (head)
    );

    always_comb begin
        redirect   = i_if_req & (i_if_addr != exp_pc_q);
        used       = {1'b0, count} + {1'b0, out_q};
        o_if_rsp   = i_if_req & ~redirect & (count != '0);
        o_if_data  = o_if_rsp ? head : INST_NOP;
        pop        = o_if_rsp & i_if_ack;
        o_mem_req  = i_rst_n & ~redirect & (used < (CW+1)'(DEPTH));
        o_mem_addr = fetch_pc_q;
        gnt        = o_mem_req & i_mem_gnt;
        drop       = i_mem_rvalid & (disc_q != '0);
        push       = i_mem_rvalid & ~drop;
        out_d      = out_q + CW'(gnt) - CW'(i_mem_rvalid);
        // after a redirect every fetch still in flight belongs to the old stream
        disc_d     = redirect ? out_d : disc_q - CW'(drop);
        exp_pc_d   = redirect ? i_if_addr : pop ? pc_next(exp_pc_q) : exp_pc_q;
        fetch_pc_d = redirect ? i_if_addr : gnt ? pc_next(fetch_pc_q) : fetch_pc_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exp_pc_q   <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
        end else begin
            exp_pc_q   <= exp_pc_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
        end
    end

    a_occupancy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (used <= (CW+1)'(DEPTH)) && (disc_q <= out_q));
endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
// tb_ifetch_prefetch_buf: directed stimulus with a queue-based reference model of the prefetcher
// and a latency-configurable instruction memory.
module tb_ifetch_prefetch_buf;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] KEY   = 32'hDEAD_BEEF;

    logic        clk, rst_n;
    logic        i_if_req, i_if_ack, i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_if_addr, i_mem_rdata;
    logic        o_if_rsp, o_mem_req;
    logic [31:0] o_if_data, o_mem_addr;

    ifetch_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .i_if_ack     (i_if_ack),
        .o_if_rsp     (o_if_rsp),
        .o_if_data    (o_if_data),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { int due; logic [31:0] a; } mreq_t;
    typedef struct { bit stale; logic [31:0] a; } pend_t;

    mreq_t       memq[$];
    pend_t       pend[$];
    logic [31:0] mq[$];
    logic [31:0] m_exp, m_fetch;
    int          cyc = 0;
    int          lat = 1;

    logic        m_redir, e_rsp, e_req, ret_push;
    logic [31:0] e_data;
    pend_t       pe;

    // reference model: buffered words, in-flight fetches tagged stale/live, and the two PCs
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_if_rsp", o_if_rsp, 0);
            chk("reset_if_data", o_if_data, NOP);
            chk("reset_mem_req", o_mem_req, 0);
            mq.delete();
            pend.delete();
            memq.delete();
            m_exp = 32'h0;
            m_fetch = 32'h0;
        end else begin
            m_redir = i_if_req && (i_if_addr != m_exp);
            e_rsp   = i_if_req && !m_redir && (mq.size() > 0);
            e_data  = e_rsp ? mq[0] : NOP;
            e_req   = !m_redir && (mq.size() + pend.size() < DEPTH);
            chk("if_rsp", o_if_rsp, e_rsp);
            chk("if_data", o_if_data, e_data);
            chk("mem_req", o_mem_req, e_req);
            chk("mem_addr", o_mem_addr, m_fetch);
            if (o_mem_req && i_mem_gnt) memq.push_back('{cyc + lat, o_mem_addr});
            ret_push = 1'b0;
            if (i_mem_rvalid) begin
                chk("rvalid_outstanding", pend.size() != 0, 1);
                if (pend.size() != 0) begin
                    pe = pend.pop_front();
                    ret_push = !pe.stale && !m_redir;
                end
            end
            if (e_rsp && i_if_ack) begin
                void'(mq.pop_front());
                m_exp += 32'd4;
            end
            if (ret_push) mq.push_back(memw(pe.a));
            if (e_req && i_mem_gnt) begin
                pend.push_back('{1'b0, m_fetch});
                m_fetch += 32'd4;
            end
            if (m_redir) begin
                mq.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                m_exp = i_if_addr;
                m_fetch = i_if_addr;
            end
        end
    end

    logic        ob_rsp, ob_req, ob_gnt;
    logic [31:0] ob_data, ob_addr, pc;
    logic [31:0] hit_log[$], gnt_log[$];
    int          first_hit;

    task automatic tick(input logic req, input logic [31:0] addr, input logic ack, input logic gnt);
        i_if_req = req;
        i_if_addr = addr;
        i_if_ack = ack;
        i_mem_gnt = gnt;
        @(negedge clk);
        ob_rsp = o_if_rsp;
        ob_data = o_if_data;
        ob_req = o_mem_req;
        ob_addr = o_mem_addr;
        ob_gnt = o_mem_req & gnt;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n && memq.size() > 0 && memq[0].due <= cyc) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata = memw(memq[0].a);
            void'(memq.pop_front());
        end else begin
            i_mem_rvalid = 1'b0;
            i_mem_rdata = 32'h0;
        end
    endtask

    task automatic clear_logs();
        hit_log.delete();
        gnt_log.delete();
        first_hit = -1;
    endtask

    task automatic if_run(input int n, input logic ack, input logic gnt);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, pc, ack, gnt);
            if (ob_gnt) gnt_log.push_back(ob_addr);
            if (ob_rsp && ack) begin
                hit_log.push_back(ob_data);
                if (first_hit < 0) first_hit = i;
                pc += 32'd4;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick(1'b0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b1;
        pc = 32'h0;
        clear_logs();
    endtask

    logic [3:0] gpat;

    initial begin
        rst_n = 1'b0;
        i_if_req = 1'b0;
        i_if_addr = 32'h0;
        i_if_ack = 1'b0;
        i_mem_gnt = 1'b1;
        i_mem_rvalid = 1'b0;
        i_mem_rdata = 32'h0;
        lat = 1;

        // sequential run, 1-cycle memory, IF consuming every cycle
        do_reset(3);
        chk("reset_req_literal", ob_req, 0);
        if_run(12, 1'b1, 1'b1);
        chk("t1_first_hit_cycle", first_hit, 2);
        chk("t1_hits", hit_log.size(), 10);
        chk("t1_gnt0", gnt_log[0], 32'h0);
        chk("t1_gnt1", gnt_log[1], 32'h4);
        chk("t1_gnt2", gnt_log[2], 32'h8);
        chk("t1_data0", hit_log[0], 32'hDEAD_BEEF);
        chk("t1_data1", hit_log[1], 32'hDEAD_BEEB);

        // IF stalled: exactly DEPTH grants, then drain back-to-back and refill
        do_reset(2);
        if_run(8, 1'b0, 1'b1);
        chk("t2_stall_gnts", gnt_log.size(), 4);
        chk("t2_stall_req_off", ob_req, 0);
        chk("t2_stall_gnt3", gnt_log[3], 32'hC);
        clear_logs();
        if_run(10, 1'b1, 1'b1);
        chk("t2_hits", hit_log.size(), 10);
        chk("t2_first_hit", first_hit, 0);
        chk("t2_data3", hit_log[3], 32'hDEAD_BEE3);
        chk("t2_refill_gnt", gnt_log[0], 32'h10);

        // redirect to 0x100 with 2 outstanding and 1 buffered, 3-cycle memory
        do_reset(2);
        lat = 3;
        gpat = 4'b1001;
        for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b0, (i == 4) ? 1'b1 : gpat[i]);
        chk("t3_pre_outstanding", dut.out_q, 2);
        chk("t3_pre_count", dut.u_fifo.cnt_q, 1);
        tick(1'b1, 32'h100, 1'b1, 1'b1);
        chk("t3_redir_rsp", ob_rsp, 0);
        chk("t3_redir_req", ob_req, 0);
        chk("t3_discard", dut.disc_q, 2);
        pc = 32'h100;
        clear_logs();
        if_run(12, 1'b1, 1'b1);
        chk("t3_first_addr", gnt_log[0], 32'h100);
        chk("t3_first_data", hit_log[0], 32'hDEAD_BFEF);
        chk("t3_discard_done", dut.disc_q, 0);

        // redirect in the same cycle as an rvalid
        do_reset(2);
        gpat = 4'b0111;
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b0, gpat[i]);
        tick(1'b1, 32'h200, 1'b1, 1'b1);
        chk("t4_redir_rsp", ob_rsp, 0);
        chk("t4_discard", dut.disc_q, 1);
        chk("t4_outstanding", dut.out_q, 1);
        chk("t4_fifo_empty", dut.u_fifo.cnt_q, 0);
        pc = 32'h200;
        clear_logs();
        if_run(12, 1'b1, 1'b1);
        chk("t4_first_data", hit_log[0], 32'hDEAD_BCEF);

        // address wrap-around
        lat = 1;
        pc = 32'hFFFF_FFF8;
        clear_logs();
        if_run(10, 1'b1, 1'b1);
        chk("t5_gnt0", gnt_log[0], 32'hFFFF_FFF8);
        chk("t5_gnt1", gnt_log[1], 32'hFFFF_FFFC);
        chk("t5_gnt2", gnt_log[2], 32'h0);
        chk("t5_gnt3", gnt_log[3], 32'h4);
        chk("t5_data0", hit_log[0], 32'h2152_4117);
        chk("t5_data1", hit_log[1], 32'h2152_4113);
        chk("t5_data2", hit_log[2], 32'hDEAD_BEEF);

        // async reset mid-cycle with a full buffer
        if_run(8, 1'b0, 1'b1);
        chk("t6_full", dut.u_fifo.cnt_q, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_req", o_mem_req, 0);
        chk("t6_async_rsp", o_if_rsp, 0);
        chk("t6_async_data", o_if_data, NOP);
        do_reset(2);
        if_run(6, 1'b1, 1'b1);
        chk("t6_restart_addr", gnt_log[0], 32'h0);
        chk("t6_restart_data", hit_log[0], 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
